// File: rtl/uitpg_pkg.sv
// uitpg_gen2 shared definitions: pattern mode codes, sync bundle,
// and the eight-entry colour-bar table as {R,G,B} flags.
package uitpg_pkg;

   localparam logic [3:0] MODE_BLACK = 4'd0;
   localparam logic [3:0] MODE_WHITE = 4'd1;
   localparam logic [3:0] MODE_RED   = 4'd2;
   localparam logic [3:0] MODE_GREEN = 4'd3;
   localparam logic [3:0] MODE_BLUE  = 4'd4;
   localparam logic [3:0] MODE_GRID  = 4'd5;
   localparam logic [3:0] MODE_HRAMP = 4'd6;
   localparam logic [3:0] MODE_VRAMP = 4'd7;
   localparam logic [3:0] MODE_BARS  = 4'd8;

   localparam int NUM_MODES = 9;

   typedef struct packed {
      logic vs;
      logic hs;
      logic de;
   } sync_t;

   // White, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      logic [2:0] rgb;
      unique case (idx)
         3'd0:    rgb = 3'b111;
         3'd1:    rgb = 3'b110;
         3'd2:    rgb = 3'b011;
         3'd3:    rgb = 3'b010;
         3'd4:    rgb = 3'b101;
         3'd5:    rgb = 3'b100;
         3'd6:    rgb = 3'b001;
         default: rgb = 3'b000;
      endcase
      return rgb;
   endfunction

   function automatic logic [3:0] next_mode(input logic [3:0] m);
      return (m >= 4'(NUM_MODES - 1)) ? MODE_BLACK : m + 4'd1;
   endfunction

endpackage

// File: rtl/uitpg_timing.sv
// uitpg_gen2 timing front end: sync polarity/edge detect, pixel and
// line counters, colour-bar index, and the two-stage sync delay line.
module uitpg_timing
   import uitpg_pkg::*;
#(
   parameter int CNT_W    = 12,
   parameter int BAR_W    = 160,
   parameter int SYNC_POL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vs,
   input  logic             hs,
   input  logic             de,
   output logic             vs_edge,
   output logic             s1_de,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic [2:0]       bar_idx,
   output sync_t            sync_out
);

   localparam logic POL = (SYNC_POL != 0);
   localparam int   BCW = $clog2(BAR_W + 1);

   sync_t          s1;
   sync_t          s2;
   logic [BCW-1:0] bar_cnt;
   logic           vs_act;
   logic           vs_act_q;
   logic           de_run;
   logic           de_fall;

   assign vs_act   = (vs == POL);
   assign vs_act_q = (s1.vs == POL);
   assign vs_edge  = vs_act & ~vs_act_q;
   assign de_run   = de & s1.de;
   assign de_fall  = ~de & s1.de;
   assign s1_de    = s1.de;
   assign sync_out = s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
         bar_cnt <= '0;
         bar_idx <= '0;
      end else begin
         s1    <= {vs, hs, de};
         s2    <= s1;
         h_cnt <= de_run ? h_cnt + 1'b1 : '0;
         // A frame start overrides a coincident line end
         if (vs_edge)
            v_cnt <= '0;
         else if (de_fall)
            v_cnt <= v_cnt + 1'b1;
         if (!de_run) begin
            bar_cnt <= '0;
            bar_idx <= '0;
         end else if (bar_cnt == BCW'(BAR_W - 1)) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7)
               bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_cnt <= bar_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uitpg_gen2.sv
// Second-generation video test pattern generator, 2-cycle aligned.
// Optional horizontal scroll of grid/h-ramp under `define TPG_SCROLL_EN.
module uitpg_gen2
   import uitpg_pkg::*;
#(
   parameter int DATA_W          = 8,
   parameter int CNT_W           = 12,
   parameter int GRID_LOG2       = 4,
   parameter int BAR_W           = 160,
   parameter int FRAMES_PER_MODE = 16,
   parameter int SYNC_POL        = 1,
   parameter int SCROLL_STEP     = 1
) (
   input  logic                I_tpg_clk,
   input  logic                I_tpg_rst,
   input  logic                I_tpg_vs,
   input  logic                I_tpg_hs,
   input  logic                I_tpg_de,
   input  logic [3:0]          I_mode_sel,
   input  logic                I_auto_en,
   output logic                O_tpg_vs,
   output logic                O_tpg_hs,
   output logic                O_tpg_de,
   output logic [3*DATA_W-1:0] O_tpg_data,
   output logic [15:0]         O_frame_cnt
);

   localparam int ACW = $clog2(FRAMES_PER_MODE + 1);
   localparam int RW  = (DATA_W < CNT_W) ? DATA_W : CNT_W;
   localparam logic [DATA_W-1:0] FULL = '1;
   localparam logic [DATA_W-1:0] ZERO = '0;

   logic                vs_edge;
   logic                s1_de;
   logic [CNT_W-1:0]    h_cnt;
   logic [CNT_W-1:0]    v_cnt;
   logic [CNT_W-1:0]    x;
   logic [2:0]          bar_idx;
   logic [2:0]          rgb;
   sync_t               sync_out;
   logic [3:0]          mode_q;
   logic [ACW-1:0]      auto_cnt;
   logic [15:0]         frame_cnt;
   logic [DATA_W-1:0]   h_ramp;
   logic [DATA_W-1:0]   v_ramp;
   logic [3*DATA_W-1:0] pix;
   logic [3*DATA_W-1:0] data_q;

   uitpg_timing #(
      .CNT_W   (CNT_W),
      .BAR_W   (BAR_W),
      .SYNC_POL(SYNC_POL)
   ) u_timing (
      .clk     (I_tpg_clk),
      .rst     (I_tpg_rst),
      .vs      (I_tpg_vs),
      .hs      (I_tpg_hs),
      .de      (I_tpg_de),
      .vs_edge (vs_edge),
      .s1_de   (s1_de),
      .h_cnt   (h_cnt),
      .v_cnt   (v_cnt),
      .bar_idx (bar_idx),
      .sync_out(sync_out)
   );

`ifdef TPG_SCROLL_EN
   logic [CNT_W-1:0] scroll_ofs;

   always_ff @(posedge I_tpg_clk) begin
      if (I_tpg_rst)
         scroll_ofs <= '0;
      else if (vs_edge)
         scroll_ofs <= scroll_ofs + CNT_W'(SCROLL_STEP);
   end

   assign x = h_cnt + scroll_ofs;
`else
   assign x = h_cnt;
`endif

   // Mode only changes on a frame boundary
   always_ff @(posedge I_tpg_clk) begin
      if (I_tpg_rst) begin
         mode_q    <= MODE_BLACK;
         auto_cnt  <= '0;
         frame_cnt <= '0;
         data_q    <= '0;
      end else begin
         data_q <= s1_de ? pix : '0;
         if (vs_edge) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (!I_auto_en) begin
               mode_q   <= I_mode_sel;
               auto_cnt <= '0;
            end else if (auto_cnt == ACW'(FRAMES_PER_MODE)) begin
               mode_q   <= next_mode(mode_q);
               auto_cnt <= ACW'(1);
            end else begin
               auto_cnt <= auto_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      h_ramp = '0;
      v_ramp = '0;
      h_ramp[RW-1:0] = x[RW-1:0];
      v_ramp[RW-1:0] = v_cnt[RW-1:0];
      rgb = bar_rgb(bar_idx);
      pix = '0;
      case (mode_q)
         MODE_WHITE: pix = {FULL, FULL, FULL};
         MODE_RED:   pix = {FULL, ZERO, ZERO};
         MODE_GREEN: pix = {ZERO, FULL, ZERO};
         MODE_BLUE:  pix = {ZERO, ZERO, FULL};
         MODE_GRID:
            pix = (x[GRID_LOG2] ^ v_cnt[GRID_LOG2]) ?
                  '0 : {FULL, FULL, FULL};
         MODE_HRAMP: pix = {h_ramp, h_ramp, h_ramp};
         MODE_VRAMP: pix = {v_ramp, v_ramp, v_ramp};
         MODE_BARS:
            pix = {{DATA_W{rgb[2]}},
                   {DATA_W{rgb[1]}},
                   {DATA_W{rgb[0]}}};
         default:    pix = '0;
      endcase
   end

   assign O_tpg_vs    = sync_out.vs;
   assign O_tpg_hs    = sync_out.hs;
   assign O_tpg_de    = sync_out.de;
   assign O_tpg_data  = data_q;
   assign O_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_uitpg_gen2.sv
// Directed bench for uitpg_gen2: vector table of pattern pixels plus
// sequences for mode latching, auto-cycling, mid-frame reset and scroll.
module tb_uitpg_gen2;

   logic        I_tpg_clk = 1'b0;
   logic        I_tpg_rst;
   logic        I_tpg_vs;
   logic        I_tpg_hs;
   logic        I_tpg_de;
   logic [3:0]  I_mode_sel;
   logic        I_auto_en;
   logic        O_tpg_vs;
   logic        O_tpg_hs;
   logic        O_tpg_de;
   logic [23:0] O_tpg_data;
   logic [15:0] O_frame_cnt;

   always #5 I_tpg_clk = ~I_tpg_clk;

   uitpg_gen2 #(
      .BAR_W          (4),
      .FRAMES_PER_MODE(2)
   ) dut (
      .I_tpg_clk  (I_tpg_clk),
      .I_tpg_rst  (I_tpg_rst),
      .I_tpg_vs   (I_tpg_vs),
      .I_tpg_hs   (I_tpg_hs),
      .I_tpg_de   (I_tpg_de),
      .I_mode_sel (I_mode_sel),
      .I_auto_en  (I_auto_en),
      .O_tpg_vs   (O_tpg_vs),
      .O_tpg_hs   (O_tpg_hs),
      .O_tpg_de   (O_tpg_de),
      .O_tpg_data (O_tpg_data),
      .O_frame_cnt(O_frame_cnt)
   );

   typedef struct {
      logic vs;
      logic hs;
      logic de;
      int   ln;
      int   px;
   } hist_t;

   typedef struct {
      logic [3:0]  mode;
      int          ln;
      int          px;
      logic [23:0] exp;
   } vec_t;

   hist_t       hist [4];
   logic [23:0] img [20][64];
   vec_t        vt [$];
   int          cyc_n;
   int          n_cmp;
   int          n_err;
   int          align_err;
   int          blank_err;
   int          vs_edges;
   bit          chk_align;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Outputs seen at this negedge belong to the inputs of two calls ago
   task automatic cyc(input logic v, input logic h, input logic d,
                      input int ln, input int px);
      hist_t o;
      @(negedge I_tpg_clk);
      o = hist[(cyc_n + 2) % 4];
      if (chk_align) begin
         if ({O_tpg_vs, O_tpg_hs, O_tpg_de} !== {o.vs, o.hs, o.de})
            align_err++;
         if (!O_tpg_de && O_tpg_data !== 24'h0)
            blank_err++;
      end
      if (o.de && O_tpg_de && o.ln >= 0 && o.ln < 20 &&
          o.px >= 0 && o.px < 64)
         img[o.ln][o.px] = O_tpg_data;
      I_tpg_vs = v;
      I_tpg_hs = h;
      I_tpg_de = d;
      hist[cyc_n % 4] = '{v, h, d, ln, px};
      cyc_n++;
   endtask

   task automatic clear_img();
      for (int l = 0; l < 20; l++)
         for (int p = 0; p < 64; p++)
            img[l][p] = 24'hDEAD01;
   endtask

   task automatic run_frame(input int w, input int hgt, input int chg_ln,
                            input logic [3:0] chg_mode);
      clear_img();
      cyc(1, 0, 0, -1, 0);
      cyc(1, 0, 0, -1, 0);
      vs_edges++;
      repeat (3) cyc(0, 0, 0, -1, 0);
      for (int l = 0; l < hgt; l++) begin
         if (l == chg_ln)
            I_mode_sel = chg_mode;
         for (int p = 0; p < w; p++)
            cyc(0, 0, 1, l, p);
         repeat (2) cyc(0, 1, 0, -1, 0);
         repeat (4) cyc(0, 0, 0, -1, 0);
      end
   endtask

   function automatic logic [23:0] auto_exp(input int m, input int k);
      logic [7:0] b;
      case (m)
         0: auto_exp = 24'h000000;
         1: auto_exp = 24'hFFFFFF;
         2: auto_exp = 24'hFF0000;
         3: auto_exp = 24'h00FF00;
         4: auto_exp = 24'h0000FF;
         5: auto_exp = 24'hFFFFFF;
         6: auto_exp = 24'h020202;
         7: auto_exp = 24'h010101;
         default: auto_exp = 24'hFFFFFF;
      endcase
`ifdef TPG_SCROLL_EN
      if (m == 6) begin
         b = 8'(2 + k);
         auto_exp = {b, b, b};
      end
`else
      b = 8'(k);
      if (b == 8'hFF)
         auto_exp = 24'h0;
`endif
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         bad;
      int         m;
      vec_t       v;
      logic [23:0] e;
      logic [7:0]  b;
      n_cmp = 0;
      n_err = 0;
      align_err = 0;
      blank_err = 0;
      vs_edges = 0;
      cyc_n = 0;
      chk_align = 0;
      for (int i = 0; i < 4; i++)
         hist[i] = '{1'b0, 1'b0, 1'b0, -1, 0};
      I_tpg_rst = 1'b1;
      I_tpg_vs = 1'b0;
      I_tpg_hs = 1'b0;
      I_tpg_de = 1'b0;
      I_mode_sel = 4'd2;
      I_auto_en = 1'b0;
      repeat (4) cyc(0, 0, 0, -1, 0);
      check("rst_data", O_tpg_data, 24'h0);
      check("rst_sync", {O_tpg_vs, O_tpg_hs, O_tpg_de}, 3'b000);
      check("rst_fcnt", O_frame_cnt, 16'd0);
      I_tpg_rst = 1'b0;
      chk_align = 1;

      // Solid red over a whole frame
      run_frame(64, 20, -1, 4'd0);
      bad = 0;
      for (int l = 0; l < 20; l++)
         for (int p = 0; p < 64; p++)
            if (img[l][p] !== 24'hFF0000)
               bad++;
      check("red_all", bad, 0);

      // Selection change mid-frame waits for the next frame start
      run_frame(64, 20, 10, 4'd3);
      check("hold_red_top", img[5][5], 24'hFF0000);
      check("hold_red_bot", img[15][5], 24'hFF0000);
      run_frame(64, 20, -1, 4'd0);
      check("green_next", img[0][0], 24'h00FF00);

      vt.push_back('{4'd0, 3, 5, 24'h000000});
      vt.push_back('{4'd1, 10, 10, 24'hFFFFFF});
      vt.push_back('{4'd3, 1, 1, 24'h00FF00});
      vt.push_back('{4'd4, 2, 2, 24'h0000FF});
      vt.push_back('{4'd5, 0, 15, 24'hFFFFFF});
      vt.push_back('{4'd5, 0, 16, 24'h000000});
      vt.push_back('{4'd5, 16, 16, 24'hFFFFFF});
      vt.push_back('{4'd5, 16, 0, 24'h000000});
      vt.push_back('{4'd6, 0, 0, 24'h000000});
      vt.push_back('{4'd6, 2, 5, 24'h050505});
      vt.push_back('{4'd6, 7, 63, 24'h3F3F3F});
      vt.push_back('{4'd7, 0, 3, 24'h000000});
      vt.push_back('{4'd7, 5, 9, 24'h050505});
      vt.push_back('{4'd7, 19, 1, 24'h131313});
      vt.push_back('{4'd8, 0, 0, 24'hFFFFFF});
      vt.push_back('{4'd8, 0, 3, 24'hFFFFFF});
      vt.push_back('{4'd8, 0, 4, 24'hFFFF00});
      vt.push_back('{4'd8, 0, 7, 24'hFFFF00});
      vt.push_back('{4'd8, 0, 8, 24'h00FFFF});
      vt.push_back('{4'd8, 0, 12, 24'h00FF00});
      vt.push_back('{4'd8, 0, 16, 24'hFF00FF});
      vt.push_back('{4'd8, 0, 20, 24'hFF0000});
      vt.push_back('{4'd8, 0, 24, 24'h0000FF});
      vt.push_back('{4'd8, 1, 28, 24'h000000});
      vt.push_back('{4'd8, 2, 31, 24'h000000});
      vt.push_back('{4'd8, 3, 40, 24'h000000});
      vt.push_back('{4'd8, 1, 0, 24'hFFFFFF});
      vt.push_back('{4'd12, 1, 10, 24'h000000});

      m = 3;
      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         if (int'(v.mode) != m) begin
            I_mode_sel = v.mode;
            run_frame(64, 20, -1, 4'd0);
            m = int'(v.mode);
         end
         e = v.exp;
`ifdef TPG_SCROLL_EN
         if (v.mode == 4'd5) begin
            bad = (v.px + vs_edges) % 4096;
            e = ((((bad >> 4) ^ (v.ln >> 4)) & 1) != 0) ?
                24'h000000 : 24'hFFFFFF;
         end else if (v.mode == 4'd6) begin
            b = 8'(v.px + vs_edges);
            e = {b, b, b};
         end
`endif
         check($sformatf("vec%0d_m%0d_x%0d_y%0d", i, v.mode, v.px, v.ln),
               img[v.ln][v.px], e);
      end

      // Auto-cycling from reset: each mode lasts two frames
      I_tpg_rst = 1'b1;
      repeat (3) cyc(0, 0, 0, -1, 0);
      I_tpg_rst = 1'b0;
      vs_edges = 0;
      I_auto_en = 1'b1;
      I_mode_sel = 4'd4;
      for (int k = 1; k <= 19; k++) begin
         run_frame(8, 2, -1, 4'd0);
         m = ((k - 1) / 2) % 9;
         check($sformatf("auto_f%0d_m%0d", k, m), img[1][2],
               auto_exp(m, vs_edges));
         if (k == 18)
            check("auto_fcnt18", O_frame_cnt, 16'd18);
      end
      I_auto_en = 1'b0;

      // Reset in the middle of an active line
      I_mode_sel = 4'd1;
      run_frame(8, 2, -1, 4'd0);
      clear_img();
      cyc(1, 0, 0, -1, 0);
      cyc(1, 0, 0, -1, 0);
      repeat (2) cyc(0, 0, 0, -1, 0);
      for (int p = 0; p < 10; p++)
         cyc(0, 0, 1, 0, p);
      chk_align = 0;
      I_tpg_rst = 1'b1;
      vs_edges = 0;
      cyc(0, 0, 1, 0, 10);
      I_tpg_rst = 1'b0;
      check("midrst_data", O_tpg_data, 24'h0);
      check("midrst_sync", {O_tpg_vs, O_tpg_hs, O_tpg_de}, 3'b000);
      check("midrst_fcnt", O_frame_cnt, 16'd0);
      cyc(0, 0, 1, 0, 11);
      chk_align = 1;
      for (int p = 12; p < 20; p++)
         cyc(0, 0, 1, 0, p);
      repeat (2) cyc(0, 1, 0, -1, 0);
      repeat (4) cyc(0, 0, 0, -1, 0);
      check("midrst_mode0", img[0][12], 24'h000000);
      run_frame(8, 2, -1, 4'd0);
      check("post_rst_white", img[1][3], 24'hFFFFFF);

      // H-ramp pixel 0 follows the per-frame scroll offset when enabled
      I_mode_sel = 4'd6;
      for (int n = 0; n < 3; n++) begin
         run_frame(8, 2, -1, 4'd0);
`ifdef TPG_SCROLL_EN
         b = 8'(vs_edges);
`else
         b = 8'd0;
`endif
         check($sformatf("ramp_f%0d_px0", vs_edges), img[0][0], {b, b, b});
         b = b + 8'd5;
         check($sformatf("ramp_f%0d_px5", vs_edges), img[0][5], {b, b, b});
      end

      check("sync_de_alignment", align_err, 0);
      check("blank_data_zero", blank_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
